// File: rtl/instr_mem_loader_if.sv
// Program-load and fetch bus between the PC/sequencer side (master)
// and the instruction store (slave).
interface instr_mem_loader_if #(
  parameter int IW = 8,
  parameter int AW = 4
);
  logic          state;
  logic          ld_valid;
  logic [IW-1:0] ld_data;
  logic          ld_ready;
  logic          load;
  logic [AW-1:0] pc;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          prog_end;
  logic [AW:0]   word_cnt;
  logic          full;

  modport master (
    output state, ld_valid, ld_data, pc,
    input  ld_ready, load, instr, instr_valid, prog_end, word_cnt, full
  );

  modport slave (
    input  state, ld_valid, ld_data, pc,
    output ld_ready, load, instr, instr_valid, prog_end, word_cnt, full
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction store for the 4-bit microcode processor: sequential program
// load over valid/ready, then registered fetch at the PC address.
module instr_mem_loader #(
  parameter int IW = 8,
  parameter int AW = 4
) (
  input logic               clk,
  input logic               rst,
  instr_mem_loader_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {S_LOAD, S_FULL, S_EXEC} fsm_t;

  fsm_t          fsm, fsm_nxt;
  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   word_cnt;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          prog_end;
  logic          load;
  logic          rst_q;
  logic          ld_ready;
  logic          accept;
  logic          restart;
  logic          fetch;
  logic          in_prog;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm <= S_LOAD;
    else      fsm <= fsm_nxt;
  end

  // rst_q keeps ld_ready low until the first edge after reset release,
  // so a word presented during release is never written.
  always_comb begin
    fsm_nxt  = fsm;
    ld_ready = 1'b0;
    accept   = 1'b0;
    restart  = 1'b0;
    fetch    = 1'b0;
    in_prog  = {1'b0, bus.pc} < word_cnt;
    case (fsm)
      S_LOAD: begin
        ld_ready = rst && rst_q && !word_cnt[AW];
        if (bus.state) begin
          fsm_nxt = S_EXEC;
        end else if (bus.ld_valid && ld_ready) begin
          accept = 1'b1;
          if (word_cnt == {1'b0, {AW{1'b1}}}) fsm_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (bus.state) fsm_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (!bus.state) begin
          fsm_nxt = S_LOAD;
          restart = 1'b1;
        end else begin
          fetch = 1'b1;
        end
      end
      default: fsm_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      word_cnt    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      prog_end    <= 1'b0;
      load        <= 1'b0;
      rst_q       <= 1'b0;
    end else begin
      rst_q <= 1'b1;
      load  <= accept;
      if (accept) begin
        mem[wr_ptr] <= bus.ld_data;
        // Pointer parks at the last address; FULL blocks any further write.
        if (wr_ptr != '1) wr_ptr <= wr_ptr + AW'(1);
        word_cnt <= word_cnt + (AW+1)'(1);
      end
      if (restart) begin
        wr_ptr      <= '0;
        word_cnt    <= '0;
        instr       <= '0;
        instr_valid <= 1'b0;
        prog_end    <= 1'b0;
      end else if (fetch) begin
        instr       <= in_prog ? mem[bus.pc] : '0;
        instr_valid <= in_prog;
        prog_end    <= !in_prog;
      end
    end
  end

  assign bus.ld_ready    = ld_ready;
  assign bus.load        = load;
  assign bus.instr       = instr;
  assign bus.instr_valid = instr_valid;
  assign bus.prog_end    = prog_end;
  assign bus.word_cnt    = word_cnt;
  assign bus.full        = word_cnt[AW];
endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus queues expected load
// strobes and fetch results, a negedge monitor pops and compares them.
module tb_instr_mem_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int         due;
    logic [4:0] cnt;
  } load_t;

  typedef struct {
    int         due;
    logic [7:0] instr;
    logic       iv;
    logic       pe;
  } fetch_t;

  load_t  lq[$];
  fetch_t fq[$];

  instr_mem_loader_if #(.IW(8), .AW(4)) bus ();

  instr_mem_loader #(.IW(8), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: load strobes and fetch results are compared when they fall due.
  always @(negedge clk) begin
    load_t  le;
    fetch_t fe;
    if (lq.size() > 0 && lq[0].due == cyc) begin
      le = lq.pop_front();
      check("load_strobe", bus.load, 1);
      check("load_word_cnt", bus.word_cnt, le.cnt);
    end else if (bus.load) begin
      check("load_unexpected", bus.load, 0);
    end
    while (fq.size() > 0 && fq[0].due == cyc) begin
      fe = fq.pop_front();
      check("fetch_instr", bus.instr, fe.instr);
      check("fetch_instr_valid", bus.instr_valid, fe.iv);
      check("fetch_prog_end", bus.prog_end, fe.pe);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d, input int cnt);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    lq.push_back('{due: cyc + 1, cnt: 5'(cnt)});
    step();
  endtask

  task automatic fetch(input logic [3:0] p, input logic [7:0] i, input logic iv, input logic pe);
    bus.pc = p;
    fq.push_back('{due: cyc + 1, instr: i, iv: iv, pe: pe});
    step();
  endtask

  initial begin
    bus.state    = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.pc       = '0;
    #2;
    check("rst_ld_ready", bus.ld_ready, 0);
    check("rst_load", bus.load, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_instr_valid", bus.instr_valid, 0);
    check("rst_prog_end", bus.prog_end, 0);
    check("rst_word_cnt", bus.word_cnt, 0);
    check("rst_full", bus.full, 0);
    step();
    step();
    rst = 1'b1;
    step();
    check("ld_ready_after_release", bus.ld_ready, 1);

    // Three words back-to-back
    push_word(8'hA1, 1);
    push_word(8'hB2, 2);
    push_word(8'hC3, 3);
    bus.ld_valid = 1'b0;
    check("cnt_after_3", bus.word_cnt, 3);
    check("ld_ready_after_3", bus.ld_ready, 1);
    check("full_after_3", bus.full, 0);

    // Execute: fetch 0..3
    bus.state = 1'b1;
    step();
    fetch(4'd0, 8'hA1, 1'b1, 1'b0);
    fetch(4'd1, 8'hB2, 1'b1, 1'b0);
    fetch(4'd2, 8'hC3, 1'b1, 1'b0);
    fetch(4'd3, 8'h00, 1'b0, 1'b1);
    step();

    // Reload a full program
    bus.state = 1'b0;
    step();
    check("reload_cnt_clear", bus.word_cnt, 0);
    check("reload_instr_clear", bus.instr, 0);
    check("reload_prog_end_clear", bus.prog_end, 0);
    for (int i = 0; i < 16; i++) push_word(8'h10 + 8'(i), i + 1);
    check("full_flag", bus.full, 1);
    check("full_ld_ready", bus.ld_ready, 0);
    check("full_cnt", bus.word_cnt, 16);
    bus.ld_data = 8'hEE;
    step();
    step();
    bus.ld_valid = 1'b0;
    check("full_cnt_held", bus.word_cnt, 16);
    bus.state = 1'b1;
    step();
    fetch(4'd15, 8'h1F, 1'b1, 1'b0);
    fetch(4'd2, 8'h12, 1'b1, 1'b0);
    step();

    // Short reload over stale memory
    bus.state = 1'b0;
    step();
    push_word(8'h55, 1);
    push_word(8'h66, 2);
    bus.ld_valid = 1'b0;
    check("short_cnt", bus.word_cnt, 2);
    bus.state = 1'b1;
    step();
    fetch(4'd2, 8'h00, 1'b0, 1'b1);
    fetch(4'd0, 8'h55, 1'b1, 1'b0);
    fetch(4'd1, 8'h66, 1'b1, 1'b0);
    step();

    // Mode change coincident with ld_valid: no write
    bus.state = 1'b0;
    step();
    push_word(8'h77, 1);
    bus.ld_data = 8'h99;
    bus.state   = 1'b1;
    step();
    bus.ld_valid = 1'b0;
    check("coincident_cnt", bus.word_cnt, 1);
    check("exec_ld_ready", bus.ld_ready, 0);
    fetch(4'd1, 8'h00, 1'b0, 1'b1);
    fetch(4'd0, 8'h77, 1'b1, 1'b0);
    step();

    // Async reset in the middle of a load
    bus.state = 1'b0;
    step();
    for (int i = 0; i < 5; i++) push_word(8'h20 + 8'(i), i + 1);
    bus.ld_data = 8'h25;
    #6 rst = 1'b0;
    #1;
    check("async_load", bus.load, 0);
    check("async_word_cnt", bus.word_cnt, 0);
    check("async_full", bus.full, 0);
    check("async_ld_ready", bus.ld_ready, 0);
    check("async_instr_valid", bus.instr_valid, 0);
    step();
    rst = 1'b1;
    step();
    bus.ld_valid = 1'b0;
    step();
    check("release_no_write", bus.word_cnt, 0);
    bus.state = 1'b1;
    step();
    fetch(4'd0, 8'h00, 1'b0, 1'b1);
    fetch(4'd3, 8'h00, 1'b0, 1'b1);
    step();
    bus.state = 1'b0;
    step();

    check("load_queue_drained", lq.size(), 0);
    check("fetch_queue_drained", fq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Instruction store for the 4-bit microcode processor, sitting on the far side of the program-counter interface.
- In load mode it accepts program words over a valid/ready handshake and writes them sequentially. For each accepted word it emits the `load` strobe that advances the PC.
- In execute mode it is the reader: it returns the registered instruction at the PC-supplied address each cycle, flagging fetches past the end of the loaded program.

Parameters:
- IW, 8, instruction word width in bits
- AW, 4, address width; depth is 2**AW (16 words), matching the 4-bit pc

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- state  input  1  program state: 0 = load mode, 1 = execute mode
- ld_valid  input  1  load word present on ld_data
- ld_data  input  IW  program word to store
- ld_ready  output  1  block can accept a load word this cycle
- load  output  1  one-cycle strobe per accepted word, fed to the PC load enable
- pc  input  AW  fetch address from the program counter
- instr  output  IW  fetched instruction, registered
- instr_valid  output  1  instr holds a fetch from a loaded address
- prog_end  output  1  last fetch address was at or beyond the loaded word count
- word_cnt  output  AW+1  number of words loaded (0..16)
- full  output  1  word_cnt == 16

Behaviour:
- Reset (rst=0, async):
  - all 16 memory words = 0; wr_ptr = 0; word_cnt = 0
  - instr = 0; instr_valid = 0; prog_end = 0; load = 0; FSM = LOAD
  - ld_ready is combinational and reads 0 while in reset.
- FSM states:
  - LOAD:
    - ld_ready = (word_cnt < 16).
    - On a clock edge with ld_valid && ld_ready: mem[wr_ptr] <= ld_data; wr_ptr++; word_cnt++; load = 1 for the following cycle only.
    - When word_cnt reaches 16, go to FULL.
  - FULL:
    - ld_ready = 0; ld_valid is ignored; load stays 0; memory is held.
  - EXEC:
    - ld_ready = 0; load = 0.
    - Every cycle: instr <= mem[pc].
    - instr_valid <= (pc < word_cnt).
    - prog_end <= (pc >= word_cnt).
    - When pc >= word_cnt, instr <= 0 (NOP) instead of the stale memory content.
- Transitions:
  - state=1 sampled at a clock edge, from LOAD or FULL → EXEC. The first fetch result appears on the next edge.
  - state=0 sampled in EXEC → LOAD:
    - wr_ptr and word_cnt clear to 0 in that same edge; memory contents are retained (overwritten by the new load).
    - instr, instr_valid and prog_end clear to 0.
  - state=0 in FULL stays FULL until a state=1 → state=0 sequence passes through EXEC. Reloading always restarts at address 0.
- Latency:
  - Fetch: address on pc at edge N → instr/instr_valid valid after edge N+1 (1 cycle).
  - Load strobe: asserted during the cycle after the accepting edge.
- Simultaneous events:
  - A state change in the same cycle as ld_valid: the mode transition wins and no write occurs.
  - ld_valid held high across consecutive cycles writes one word per cycle (back-to-back, no bubble).
- Empty program (word_cnt=0) in EXEC: every fetch returns instr=0, instr_valid=0, prog_end=1.
- Reset asserted mid-load or mid-execution:
  - Immediate return to reset values; memory is cleared.
  - Release is synchronous to the next rising clk, with no write on that edge.
- Widths:
  - word_cnt is AW+1 bits so that 16 is representable.
  - wr_ptr is AW bits and never wraps; FULL blocks further writes.

Test Plan:
- Reset, then release with state=0; push 3 words 0xA1, 0xB2, 0xC3 back-to-back → load pulses on 3 consecutive cycles; word_cnt=3; ld_ready stays 1.
- Switch state=1; drive pc=0,1,2,3 on successive cycles → instr = 0xA1, 0xB2, 0xC3, then 0x00 one cycle later each; instr_valid = 1,1,1,0; prog_end rises on the pc=3 fetch.
- Load 16 words 0x10..0x1F → full=1 and ld_ready=0 after the 16th; a 17th ld_valid produces no load pulse; EXEC with pc=15 → instr=0x1F, instr_valid=1.
- In EXEC, drop state=0 and reload 2 words 0x55, 0x66 → word_cnt=2; EXEC with pc=2 → instr=0, prog_end=1 even though the memory still holds the old 0x12 at address 2.
- Assert rst=0 asynchronously mid-load after 5 words → all outputs 0 immediately; after release, EXEC with pc=0 → instr=0, instr_valid=0.
- ld_valid=1 on the same edge state goes 0→1 → no write; word_cnt unchanged; load stays 0.
